// File: rtl/quiz_round_ctrl.sv
// Two-player quiz round controller: debounced remote decode, answer judging, scoring.
// Optional build macro QUIZ_TIMEOUT_EN adds a WAIT timeout that abandons the question.
module quiz_round_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int NUM_Q        = 10,
  parameter int WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] joy_n,
  input  logic [3:0] q_ans,
  output logic [3:0] q_idx,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic [2:0] phase,
  output logic       hit,
  output logic       miss,
  output logic       beep
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ASK   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_JUDGE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYC);
  localparam logic [3:0]    Q_LAST   = 4'(NUM_Q - 1);
  localparam logic [2:0]    WIN_VAL  = 3'(WIN_SCORE);

`ifdef QUIZ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  logic [7:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rel_pend_q, rel_pend_d;
  logic          acc_q, acc_d;
  logic          acc_p2_q, acc_p2_d;
  logic [1:0]    acc_ans_q, acc_ans_d;

  logic [2:0]    phase_q, phase_d;
  logic [3:0]    q_idx_q, q_idx_d;
  logic [2:0]    score_p1_q, score_p1_d;
  logic [2:0]    score_p2_q, score_p2_d;
  logic          lock1_q, lock1_d;
  logic          lock2_q, lock2_d;
  logic          jp2_q, jp2_d;
  logic [1:0]    jans_q, jans_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;

  logic          pat_legal;
  logic          pat_p2;
  logic [1:0]    pat_ans;
  logic          stable;
  logic          accept;

  // Debounce: run length of an unchanged joy_n value, saturating at DEBOUNCE_CYC.
  always_comb begin
    pat_legal = 1'b1;
    pat_p2    = 1'b0;
    pat_ans   = 2'd0;
    case (joy_n)
      8'h7F: pat_ans = 2'd0;
      8'hBF: pat_ans = 2'd1;
      8'hDF: pat_ans = 2'd2;
      8'hEF: pat_ans = 2'd3;
      8'hF7: begin pat_p2 = 1'b1; pat_ans = 2'd0; end
      8'hFB: begin pat_p2 = 1'b1; pat_ans = 2'd1; end
      8'hFD: begin pat_p2 = 1'b1; pat_ans = 2'd2; end
      8'hFE: begin pat_p2 = 1'b1; pat_ans = 2'd3; end
      default: pat_legal = 1'b0;
    endcase

    prev_d = joy_n;
    if (joy_n != prev_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == DEB_MAX) begin
      cnt_d = DEB_MAX;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    stable = (cnt_d == DEB_MAX);
    accept = stable && pat_legal && !rel_pend_q;

    // A press must be followed by a fully released remote before the next one counts.
    rel_pend_d = rel_pend_q;
    if (accept) begin
      rel_pend_d = 1'b1;
    end else if (stable && (joy_n == 8'hFF)) begin
      rel_pend_d = 1'b0;
    end

    acc_d     = accept;
    acc_p2_d  = pat_p2;
    acc_ans_d = pat_ans;
  end

  logic [3:0] q_next;
  logic [3:0] ans_val;
  logic       correct;
  logic [2:0] cur_score;
  logic [2:0] new_score;
  logic       acc_locked;

  always_comb begin
    q_next     = (q_idx_q == Q_LAST) ? 4'd0 : q_idx_q + 4'd1;
    ans_val    = {2'b00, jans_q} + 4'd1;
    correct    = (ans_val == q_ans);
    cur_score  = jp2_q ? score_p2_q : score_p1_q;
    new_score  = (cur_score >= WIN_VAL) ? cur_score : cur_score + 3'd1;
    acc_locked = acc_p2_q ? lock2_q : lock1_q;
  end

  // Round FSM: ask, wait for an unlocked answer, judge, then next question or game over.
  always_comb begin
    phase_d    = phase_q;
    q_idx_d    = q_idx_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    lock1_d    = lock1_q;
    lock2_d    = lock2_q;
    jp2_d      = jp2_q;
    jans_d     = jans_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
`ifdef QUIZ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    case (phase_q)
      ST_IDLE: begin
        score_p1_d = 3'd0;
        score_p2_d = 3'd0;
        q_idx_d    = 4'd0;
        if (start) begin
          phase_d = ST_ASK;
        end
      end

      ST_ASK: begin
        lock1_d = 1'b0;
        lock2_d = 1'b0;
`ifdef QUIZ_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        phase_d = ST_WAIT;
      end

      ST_WAIT: begin
`ifdef QUIZ_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TW'(1);
`endif
        if (acc_q && !acc_locked) begin
          jp2_d   = acc_p2_q;
          jans_d  = acc_ans_q;
          phase_d = ST_JUDGE;
        end
`ifdef QUIZ_TIMEOUT_EN
        else if (to_cnt_d >= TO_LIM) begin
          q_idx_d = q_next;
          phase_d = ST_ASK;
        end
`endif
      end

      ST_JUDGE: begin
        if (correct) begin
          hit_d = 1'b1;
          if (jp2_q) begin
            score_p2_d = new_score;
          end else begin
            score_p1_d = new_score;
          end
          q_idx_d = q_next;
          phase_d = (new_score == WIN_VAL) ? ST_OVER : ST_ASK;
        end else begin
          miss_d = 1'b1;
          if (jp2_q) begin
            lock2_d = 1'b1;
          end else begin
            lock1_d = 1'b1;
          end
          if (jp2_q ? lock1_q : lock2_q) begin
            q_idx_d = q_next;
            phase_d = ST_ASK;
          end else begin
            phase_d = ST_WAIT;
          end
        end
      end

      ST_OVER: begin
        if (start) begin
          score_p1_d = 3'd0;
          score_p2_d = 3'd0;
          q_idx_d    = 4'd0;
          phase_d    = ST_ASK;
        end
      end

      default: phase_d = ST_IDLE;
    endcase
  end

  // Reset leaves a release wait pending so a button held through reset is not taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= 8'hFF;
      cnt_q      <= '0;
      rel_pend_q <= 1'b1;
      acc_q      <= 1'b0;
      acc_p2_q   <= 1'b0;
      acc_ans_q  <= 2'd0;
      phase_q    <= ST_IDLE;
      q_idx_q    <= 4'd0;
      score_p1_q <= 3'd0;
      score_p2_q <= 3'd0;
      lock1_q    <= 1'b0;
      lock2_q    <= 1'b0;
      jp2_q      <= 1'b0;
      jans_q     <= 2'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
`ifdef QUIZ_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      rel_pend_q <= rel_pend_d;
      acc_q      <= acc_d;
      acc_p2_q   <= acc_p2_d;
      acc_ans_q  <= acc_ans_d;
      phase_q    <= phase_d;
      q_idx_q    <= q_idx_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      lock1_q    <= lock1_d;
      lock2_q    <= lock2_d;
      jp2_q      <= jp2_d;
      jans_q     <= jans_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
`ifdef QUIZ_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign q_idx    = q_idx_q;
  assign score_p1 = score_p1_q;
  assign score_p2 = score_p2_q;
  assign phase    = phase_q;
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign beep     = (phase_q == ST_OVER);

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Randomized scoreboard bench for quiz_round_ctrl: a press-level game model predicts
// every judged answer; a monitor compares each hit/miss pulse against the queue.
module tb_quiz_round_ctrl;

  localparam int DEB  = 4;
  localparam int NQ   = 10;
  localparam int WIN  = 5;
  localparam int P_IDLE = 0;
  localparam int P_ASK  = 1;
  localparam int P_WAIT = 2;
  localparam int P_OVER = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] joy_n;
  logic [3:0] q_ans;
  logic [3:0] q_idx;
  logic [2:0] score_p1, score_p2, phase;
  logic       hit, miss, beep;

  quiz_round_ctrl #(
    .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(1000), .NUM_Q(NQ), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .joy_n(joy_n), .q_ans(q_ans),
    .q_idx(q_idx), .score_p1(score_p1), .score_p2(score_p2), .phase(phase),
    .hit(hit), .miss(miss), .beep(beep)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit isHit;
    int s1;
    int s2;
    int q;
    int ph;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int vectors = 0;
  int miscompares = 0;

  int qtable [NQ];
  logic [7:0] legalPats [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // Game-level reference state (mode: 0 idle, 1 playing, 2 over)
  int mMode, mS1, mS2, mQ;
  bit mLock1, mLock2;

  always_comb begin
    q_ans = 4'd0;
    for (int i = 0; i < NQ; i++) begin
      if (int'(q_idx) == i) q_ans = 4'(qtable[i]);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (hit || miss)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: got hit=%0d miss=%0d, expected no pulse", hit, miss);
      end else begin
        mon = sb.pop_front();
        checkOutput("hit", int'(hit), int'(mon.isHit));
        checkOutput("miss", int'(miss), int'(!mon.isHit));
        checkOutput("score_p1", int'(score_p1), mon.s1);
        checkOutput("score_p2", int'(score_p2), mon.s2);
        checkOutput("q_idx", int'(q_idx), mon.q);
        checkOutput("phase", int'(phase), mon.ph);
        checkOutput("beep", int'(beep), int'(mon.ph == P_OVER));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int patIndex(input logic [7:0] p);
    for (int i = 0; i < 8; i++) begin
      if (legalPats[i] == p) return i;
    end
    return -1;
  endfunction

  // Predict the outcome of one press from the game rules
  task automatic modelPress(input logic [7:0] pat, input int hold);
    int idx, player, ans, ph;
    exp_t e;
    idx = patIndex(pat);
    if (idx < 0 || hold < DEB || mMode != 1) return;
    player = idx / 4 + 1;
    ans    = idx % 4 + 1;
    if ((player == 1) ? mLock1 : mLock2) return;
    if (ans == qtable[mQ]) begin
      if (player == 1) mS1++; else mS2++;
      mQ = (mQ + 1) % NQ;
      mLock1 = 0;
      mLock2 = 0;
      if (mS1 == WIN || mS2 == WIN) begin
        ph = P_OVER;
        mMode = 2;
      end else begin
        ph = P_ASK;
      end
      e.isHit = 1;
    end else begin
      if (player == 1) mLock1 = 1; else mLock2 = 1;
      if (mLock1 && mLock2) begin
        mQ = (mQ + 1) % NQ;
        mLock1 = 0;
        mLock2 = 0;
        ph = P_ASK;
      end else begin
        ph = P_WAIT;
      end
      e.isHit = 0;
    end
    e.s1 = mS1;
    e.s2 = mS2;
    e.q  = mQ;
    e.ph = ph;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input int hold, input int gap);
    modelPress(pat, hold);
    joy_n = pat;
    cycles(hold);
    joy_n = 8'hFF;
    cycles(gap);
  endtask

  task automatic modelClear();
    mS1 = 0;
    mS2 = 0;
    mQ = 0;
    mLock1 = 0;
    mLock2 = 0;
  endtask

  task automatic startGame(input string tag);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(1);
    modelClear();
    mMode = 1;
    checkOutput({tag, "_phase"}, int'(phase), P_WAIT);
    checkOutput({tag, "_beep"}, int'(beep), 0);
    checkOutput({tag, "_score_p1"}, int'(score_p1), 0);
    checkOutput({tag, "_score_p2"}, int'(score_p2), 0);
    checkOutput({tag, "_q_idx"}, int'(q_idx), 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_phase"}, int'(phase), P_IDLE);
    checkOutput({tag, "_q_idx"}, int'(q_idx), 0);
    checkOutput({tag, "_score_p1"}, int'(score_p1), 0);
    checkOutput({tag, "_score_p2"}, int'(score_p2), 0);
    checkOutput({tag, "_beep"}, int'(beep), 0);
    checkOutput({tag, "_hit"}, int'(hit), 0);
    checkOutput({tag, "_miss"}, int'(miss), 0);
  endtask

  // Reset mid-press: the held button must not be taken after release until the remote idles
  task automatic resetMidPress();
    joy_n = legalPats[2 + 0];
    cycles(2);
    rst = 1'b1;
    #1;
    checkIdle("async_reset");
    cycles(2);
    rst = 1'b0;
    mMode = 0;
    modelClear();
    cycles(1);
    startGame("restart_after_reset");
    cycles(3 * DEB);
    joy_n = 8'hFF;
    cycles(DEB + 2);
  endtask

  initial begin
    logic [7:0] pat;
    int r, player, ans, hold, gap;
    for (int i = 0; i < NQ; i++) qtable[i] = $urandom_range(4, 1);
    rst   = 1'b1;
    start = 1'b0;
    joy_n = 8'hFF;
    mMode = 0;
    modelClear();
    cycles(2);
    checkIdle("reset");
    rst = 1'b0;
    cycles(DEB + 2);
    checkIdle("idle_no_start");
    startGame("first_start");

    for (int t = 0; t < 400; t++) begin
      if (t == 200) resetMidPress();
      r = $urandom_range(99);
      if (r < 80) begin
        player = $urandom_range(1, 0);
        ans = ($urandom_range(1) == 1) ? qtable[mQ] : $urandom_range(4, 1);
        pat = legalPats[player * 4 + ans - 1];
      end else begin
        do pat = 8'($urandom); while (patIndex(pat) >= 0 || pat == 8'hFF);
      end
      hold = ($urandom_range(99) < 70) ? DEB + $urandom_range(6) : $urandom_range(DEB - 1, 1);
      gap  = DEB + 3 + $urandom_range(3);
      applyStimulus(pat, hold, gap);
      if (mMode == 2) begin
        checkOutput("over_phase", int'(phase), P_OVER);
        checkOutput("over_beep", int'(beep), 1);
        checkOutput("over_score_p1", int'(score_p1), mS1);
        checkOutput("over_score_p2", int'(score_p2), mS2);
        applyStimulus(legalPats[$urandom_range(7)], DEB + 2, DEB + 3);
        checkOutput("over_held_phase", int'(phase), P_OVER);
        startGame("restart_from_over");
      end
    end

    cycles(20);
    checkOutput("scoreboard_drained", sb.size(), 0);
    checkOutput("final_score_p1", int'(score_p1), mS1);
    checkOutput("final_score_p2", int'(score_p2), mS2);
    checkOutput("final_q_idx", int'(q_idx), mQ);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive cycles a remote pattern must hold stable to be accepted.
REQ-002 Parameter TIMEOUT_CYC, default 1000: WAIT cycles before the question is abandoned.
REQ-003 Parameter NUM_Q, default 10: number of questions; q_idx wraps NUM_Q-1 -> 0.
REQ-004 Parameter WIN_SCORE, default 5: score that ends the game.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 start  in  1  level input; sampled in IDLE and OVER.
REQ-008 joy_n  in  8  active-low remote buttons; 0x7F/0xBF/0xDF/0xEF = P1 answers 1/2/3/4; 0xF7/0xFB/0xFD/0xFE = P2 answers 1/2/3/4.
REQ-009 q_ans  in  4  correct answer (1..4) for q_idx, supplied combinationally by the question table.
REQ-010 q_idx  out  4  current question index.
REQ-011 score_p1, score_p2  out  3 each  player scores, 0..WIN_SCORE.
REQ-012 phase  out  3  FSM state: IDLE=0, ASK=1, WAIT=2, JUDGE=3, OVER=4.
REQ-013 hit, miss  out  1 each  one-cycle pulses in the cycle after JUDGE for a correct or wrong answer.
REQ-014 beep  out  1  high while phase==OVER.

Function
REQ-015 Patterns other than the eight in REQ-008 (including 0xFF and multi-button) are never accepted.
REQ-016 A legal pattern is accepted in the cycle it has been stable for DEBOUNCE_CYC cycles; acceptance latches player and answer.
REQ-017 After an acceptance, joy_n must read 0xFF for DEBOUNCE_CYC consecutive cycles before any further acceptance (one press = one answer).
REQ-018 IDLE: if start==1, go to ASK; scores and q_idx are 0.
REQ-019 ASK: lasts one cycle; clears both lock flags and the timeout counter; next state WAIT.
REQ-020 WAIT: on acceptance from an unlocked player, go to JUDGE; acceptances from a locked player are discarded and do not change state.
REQ-021 Tie rule: if both players' patterns complete debounce in the same cycle, which joy_n encoding makes impossible, P1 wins; no other arbitration is required.
REQ-022 JUDGE, correct (answer==q_ans): that score +1, hit pulse, q_idx advances with wrap; next state OVER if the new score==WIN_SCORE, else ASK.
REQ-023 JUDGE, wrong: miss pulse, the player is locked for this question; if both are now locked, q_idx advances and next state is ASK, else WAIT.
REQ-024 Score and q_idx updates are visible on the edge leaving JUDGE; press-to-score latency = DEBOUNCE_CYC + 2 cycles.
REQ-025 OVER: scores are held and beep=1; start==1 clears scores and q_idx to 0 and goes to ASK.
REQ-026 Scores never exceed WIN_SCORE and never wrap.

Reset
REQ-027 rst==1 forces at once: phase=IDLE, q_idx=0, scores=0, hit=miss=beep=0, locks, debounce and timeout counters cleared, and a release wait pending.
REQ-028 Reset mid-press: after rst is released, joy_n must first read 0xFF for DEBOUNCE_CYC cycles before any acceptance.

Configuration
REQ-029 Macro QUIZ_TIMEOUT_EN defined: in WAIT a counter increments each cycle; on reaching TIMEOUT_CYC, q_idx advances and next state is ASK, with no score and no pulse.
REQ-030 Macro QUIZ_TIMEOUT_EN undefined: no timeout counter exists and WAIT is left only via JUDGE.

Verification
REQ-031 Reset, start=1, q_ans=3, joy_n=0xDF held 4 cycles -> hit pulse, score_p1=1, q_idx=1, phase=ASK then WAIT.
REQ-032 q_ans=2, P2 presses 0xF7 -> miss, P2 locked; P2 presses 0xFB again -> ignored; P1 presses 0xBF -> score_p1+1.
REQ-033 Both players answer wrong on q_idx=9 -> no score change, q_idx=0, phase=ASK.
REQ-034 joy_n glitches 0xEF for 3 cycles, then 0xFF -> no acceptance; 0xEF held for 10 cycles -> exactly one acceptance.
REQ-035 P1 reaches 5 correct answers -> phase=OVER, beep=1, further presses ignored; start=1 -> scores 0, q_idx 0, beep 0.
REQ-036 With QUIZ_TIMEOUT_EN and TIMEOUT_CYC=20: no presses for 20 WAIT cycles -> q_idx+1, scores unchanged; rst asserted in JUDGE -> IDLE at once.
